// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine.
// Mode and direction encodings used by the top and the bench.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/led_chaser_gen_if.sv
// Control and LED bundle of the pattern engine.
// master drives the controls, slave is the engine.
interface led_chaser_gen_if #(
  parameter  int NUM_LEDS  = 8,
  parameter  int DIV_WIDTH = 27,
  localparam int POS_W     = $clog2(NUM_LEDS)
);
  logic [DIV_WIDTH-1:0] period;
  logic [1:0]           mode;
  logic                 dir;
  logic                 pause;
  logic                 load;
  logic [POS_W-1:0]     load_pos;
  logic [NUM_LEDS-1:0]  leds;
  logic [POS_W-1:0]     pos;
  logic                 step_pulse;

  modport master (
    output period, mode, dir, pause, load, load_pos,
    input  leds, pos, step_pulse
  );

  modport slave (
    input  period, mode, dir, pause, load, load_pos,
    output leds, pos, step_pulse
  );
endinterface

// File: rtl/led_prescaler.sv
// Programmable step prescaler: tick every period+1 cycles.
// clear restarts the count; pause freezes it.
module led_prescaler #(
  parameter int DIV_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 pause,
  input  logic                 clear,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] presc;

  assign tick = (presc == period) && !pause && !rst && !clear;

  // presc > period after a period shrink falls back to 0 silently
  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (clear)
      presc <= '0;
    else if (pause)
      presc <= presc;
    else if (presc >= period)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end
endmodule

// File: rtl/led_chaser_gen.sv
// N-LED pattern engine: wrap, bounce, bar-graph fill and off.
// Pattern state advances on prescaler ticks; leds is a pure decode.
module led_chaser_gen
  import led_pkg::*;
#(
  parameter  int NUM_LEDS  = 8,
  parameter  int DIV_WIDTH = 27,
  localparam int POS_W     = $clog2(NUM_LEDS),
  localparam int LVL_W     = $clog2(NUM_LEDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  led_chaser_gen_if.slave  bus
);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEDS);

  logic [POS_W-1:0]    pos;
  logic [LVL_W-1:0]    level;
  logic                bdir;
  logic                dir_q;
  logic [1:0]          mode_q;
  logic                mode_chg;
  logic                step;
  logic [POS_W-1:0]    pos_ld;
  logic [NUM_LEDS-1:0] leds_d;
  mode_e               mode;

  assign mode     = mode_e'(bus.mode);
  assign mode_chg = bus.mode != mode_q;
  assign pos_ld   = (int'(bus.load_pos) > NUM_LEDS - 1) ?
                    POS_MAX : bus.load_pos;

  led_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .period (bus.period),
    .pause  (bus.pause),
    .clear  (bus.load | mode_chg),
    .tick   (step)
  );

  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
    dir_q  <= bus.dir;
    if (rst) begin
      pos    <= '0;
      level  <= '0;
      bdir   <= DIR_UP;
      mode_q <= MODE_WRAP;
      dir_q  <= DIR_UP;
    end else if (bus.load) begin
      pos   <= pos_ld;
      level <= '0;
      if (mode_chg && mode == MODE_BOUNCE)
        bdir <= bus.dir;
    end else if (mode_chg) begin
      level <= '0;
      if (mode == MODE_BOUNCE)
        bdir <= bus.dir;
    end else if (!bus.pause) begin
      if (step) begin
        unique case (mode)
          MODE_WRAP: begin
            if (bus.dir)
              pos <= (pos == POS_MAX) ? '0 : pos + 1'b1;
            else
              pos <= (pos == '0) ? POS_MAX : pos - 1'b1;
          end
          MODE_BOUNCE: begin
            if (bdir) begin
              if (pos == POS_MAX) begin
                pos  <= pos - 1'b1;
                bdir <= DIR_DOWN;
              end else begin
                pos <= pos + 1'b1;
              end
            end else begin
              if (pos == '0) begin
                pos  <= pos + 1'b1;
                bdir <= DIR_UP;
              end else begin
                pos <= pos - 1'b1;
              end
            end
          end
          MODE_FILL:
            level <= (level == LVL_MAX) ? '0 : level + 1'b1;
          MODE_OFF: ;
        endcase
      end
      // a dir edge re-aims the bounce; it wins over an end-stop flip
      if (mode == MODE_BOUNCE && bus.dir != dir_q)
        bdir <= bus.dir;
    end
  end

  always_comb begin
    leds_d = '0;
    unique case (mode)
      MODE_WRAP, MODE_BOUNCE:
        leds_d = NUM_LEDS'(1) << pos;
      MODE_FILL:
        for (int i = 0; i < NUM_LEDS; i++)
          leds_d[i] = bus.dir ? (i < int'(level))
                              : (i >= NUM_LEDS - int'(level));
      MODE_OFF:
        leds_d = '0;
    endcase
  end

  assign bus.leds       = leds_d;
  assign bus.pos        = pos;
  assign bus.step_pulse = step;
endmodule

// File: tb/tb_led_chaser_gen.sv
// Scoreboard bench for led_chaser_gen: directed plan then random.
// A behavioural model queues expected outputs; a monitor compares.
module tb_led_chaser_gen;
  import led_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int PW = 2;

  typedef struct {
    logic [N-1:0]  leds;
    logic [PW-1:0] pos;
    logic          sp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  led_chaser_gen_if #(.NUM_LEDS(N), .DIV_WIDTH(DW)) bus ();
  led_chaser_gen_if #(.NUM_LEDS(3), .DIV_WIDTH(DW)) bus3 ();

  led_chaser_gen #(.NUM_LEDS(N), .DIV_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  led_chaser_gen #(.NUM_LEDS(3), .DIV_WIDTH(DW)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  int m_presc = 0;
  int m_pos   = 0;
  int m_level = 0;
  int m_bdir  = 1;
  int m_mode  = 0;
  int m_dirq  = 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("leds", int'(bus.leds), int'(e.leds));
      chk("pos", int'(bus.pos), int'(e.pos));
      chk("step_pulse", int'(bus.step_pulse), int'(e.sp));
    end
  end

  task automatic cyc(input bit r, input int per, input int md,
                     input bit d, input bit p, input bit l,
                     input int lp);
    exp_t e;
    bit   chg;
    int   bar;
    rst          = r;
    bus.period   = DW'(per);
    bus.mode     = 2'(md);
    bus.dir      = d;
    bus.pause    = p;
    bus.load     = l;
    bus.load_pos = PW'(lp);
    chg  = (md != m_mode);
    e.sp = !r && !p && !l && !chg && (m_presc == per);
    bar  = (1 << m_level) - 1;
    case (md)
      0, 1:    e.leds = N'(1 << m_pos);
      2:       e.leds = d ? N'(bar) : N'(bar << (N - m_level));
      default: e.leds = '0;
    endcase
    e.pos = PW'(m_pos);
    q.push_back(e);
    if (r) begin
      m_presc = 0; m_pos = 0; m_level = 0;
      m_bdir = 1; m_mode = 0; m_dirq = 1;
    end else begin
      if (l) begin
        m_pos = (lp > N - 1) ? N - 1 : lp;
        m_level = 0; m_presc = 0;
        if (chg && md == 1) m_bdir = d;
      end else if (chg) begin
        m_presc = 0; m_level = 0;
        if (md == 1) m_bdir = d;
      end else if (!p) begin
        if (e.sp) begin
          case (md)
            0: m_pos = (m_pos + (d ? 1 : N - 1)) % N;
            1: begin
              if (m_bdir == 1) begin
                if (m_pos == N - 1) begin m_pos = N - 2; m_bdir = 0; end
                else m_pos++;
              end else begin
                if (m_pos == 0) begin m_pos = 1; m_bdir = 1; end
                else m_pos--;
              end
            end
            2: m_level = (m_level == N) ? 0 : m_level + 1;
            default: ;
          endcase
        end
        m_presc = (m_presc >= per) ? 0 : m_presc + 1;
        if (md == 1 && int'(d) != m_dirq) m_bdir = d;
      end
      m_mode = md;
      m_dirq = d;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int per, md, lp;
    bit d, p, l, r;
    int guard;
    rst = 1'b1;
    bus.period = DW'(2); bus.mode = 2'(0); bus.dir = 1'b1;
    bus.pause = 1'b0; bus.load = 1'b0; bus.load_pos = '0;
    @(posedge clk);
    #1;
    repeat (2) cyc(1, 2, 0, 1, 0, 0, 0);
    repeat (15) cyc(0, 2, 0, 1, 0, 0, 0);
    repeat (8) cyc(0, 2, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 2, 0, 1, 0, 0, 0);
    cyc(0, 2, 0, 1, 0, 1, 3);
    repeat (4) cyc(0, 2, 0, 1, 0, 0, 0);
    cyc(1, 2, 1, 1, 0, 0, 0);
    repeat (24) cyc(0, 2, 1, 1, 0, 0, 0);
    guard = 0;
    while (!(m_pos == 1 && m_bdir == 1 && m_presc == 0) && guard < 100) begin
      cyc(0, 2, 1, 1, 0, 0, 0);
      guard++;
    end
    chk("bounce_setup_timeout", guard < 100, 1);
    repeat (10) cyc(0, 2, 1, 0, 0, 0, 0);
    repeat (18) cyc(0, 2, 2, 1, 0, 0, 0);
    cyc(0, 2, 0, 1, 0, 0, 0);
    repeat (18) cyc(0, 2, 2, 0, 0, 0, 0);
    repeat (4) cyc(0, 2, 2, 0, 0, 0, 0);
    repeat (10) cyc(0, 2, 2, 0, 1, 0, 0);
    repeat (6) cyc(0, 2, 2, 0, 0, 0, 0);
    guard = 0;
    while (m_level != 3 && guard < 100) begin
      cyc(0, 2, 2, 1, 0, 0, 0);
      guard++;
    end
    chk("fill_setup_timeout", guard < 100, 1);
    cyc(1, 2, 2, 1, 0, 0, 0);
    repeat (4) cyc(0, 2, 0, 1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (9) cyc(0, 2, 3, 1, 0, 0, 0);
    per = 2; md = 0; d = 1;
    repeat (2500) begin
      if ($urandom_range(0, 49) == 0) per = $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) md = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) d = ~d;
      p  = ($urandom_range(0, 9) == 0);
      l  = ($urandom_range(0, 24) == 0);
      r  = ($urandom_range(0, 199) == 0);
      lp = $urandom_range(0, 3);
      cyc(r, per, md, d, p, l, lp);
    end
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", q.size(), 0);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst3 = 1'b1;
    bus3.period = DW'(2); bus3.mode = 2'(0); bus3.dir = 1'b1;
    bus3.pause = 1'b0; bus3.load = 1'b0; bus3.load_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    bus3.load = 1'b1;
    bus3.load_pos = 2'd3;
    @(posedge clk);
    #2;
    bus3.load = 1'b0;
    bus3.pause = 1'b1;
    chk("clamp_pos_n3", int'(bus3.pos), 2);
    chk("clamp_leds_n3", int'(bus3.leds), 4);
    chk("clamp_no_step_n3", int'(bus3.step_pulse), 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
